master_port: RTL and testbench
==============================

# master_port

Bus-side master interface for the two-master system bus: accepts one parallel read/write request from a local device, requests bus ownership from the arbiter, and transfers the frame serially. A write frame is address then write data. A read frame is address then read data returned by the slave. One instance sits upstream of each arbiter master input: it drives `breq1`/`breq2` and consumes `bgrant1`/`bgrant2`.

## Interface
- `ADDR_WIDTH`, 14: serial address bits (top 2 = slave id).
- `DATA_WIDTH`, 8: data bits per transfer.
- `ACK_TIMEOUT`, 16: idle-cycle limit before abort (only with macro).
- `clk` in 1: clock; all state updates on rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `dvalid` in 1: device request, sampled only when `dready`=1.
- `dmode` in 1: 1 = write, 0 = read.
- `daddr` in ADDR_WIDTH: target address.
- `dwdata` in DATA_WIDTH: write data.
- `dready` out 1: port idle, request accepted this cycle if `dvalid`=1.
- `drvalid` out 1: one-cycle completion pulse.
- `drdata` out DATA_WIDTH: last read data, held until the next read completes.
- `derr` out 1: one-cycle abort pulse (instead of `drvalid`).
- `breq` out 1: bus request to arbiter.
- `bgrant` in 1: bus grant from arbiter.
- `mwdata` out 1: serial address/write-data bit.
- `mvalid` out 1: `mwdata` valid.
- `mmode` out 1: latched mode, driven for the whole frame.
- `sack` in 1: slave address acknowledge.
- `svalid` in 1: slave read-data bit valid.
- `mrdata` in 1: serial read-data bit.

## Operation
- States: IDLE, REQ, ADDR, WAIT_ACK, WDATA, RDATA, DONE.
- IDLE: `dready`=1. When `dvalid`=1, latch `daddr`/`dwdata`/`dmode` and go to REQ. A `dvalid` asserted in any other state is ignored.
- REQ: `breq`=1. Stay until `bgrant` is sampled 1, then go to ADDR.
- ADDR: `mvalid`=1, `mwdata`=addr bit, LSB first, one bit per cycle for ADDR_WIDTH cycles (bit counter 0..ADDR_WIDTH-1). Then go to WAIT_ACK.
- WAIT_ACK: `mvalid`=0. When `sack` is sampled 1, go to WDATA (write) or RDATA (read).
- WDATA: `mvalid`=1, data LSB first for DATA_WIDTH cycles. Then go to DONE.
- RDATA: each cycle with `svalid`=1, shift `mrdata` into the receive register at the bit index, LSB first. After DATA_WIDTH bits, update `drdata` and go to DONE. Cycles with `svalid`=0 do not advance the index.
- DONE: `breq`=0, `drvalid`=1 (or `derr`=1 if aborting), then go to IDLE.
- `breq` is 1 in every state from REQ through RDATA, so the arbiter holds the grant for the whole frame. It drops only in DONE, which releases the bus.
- `bgrant` sampled 0 in ADDR, WAIT_ACK, WDATA or RDATA: abort. Go to DONE with `derr`=1 and leave `drdata` unchanged.
- `mmode` equals the latched `dmode` from REQ through DONE, and 0 in IDLE.

## Timing
- Reset (async, `rstn`=0): state IDLE, counters 0. Outputs: `breq`=0, `mvalid`=0, `mwdata`=0, `mmode`=0, `drvalid`=0, `derr`=0, `drdata`=0, `dready`=1.
- Reset mid-frame aborts immediately. No completion pulse is issued.
- All outputs are registered or decoded from state. No combinational path from inputs to outputs.
- Write latency after acceptance, with grant g cycles after `breq` and ack a cycles after ADDR: 1 + g + ADDR_WIDTH + a + DATA_WIDTH + 1 cycles to the `drvalid` pulse.
- `dready` returns to 1 the cycle after DONE, so back-to-back requests are spaced by at least one IDLE cycle.

## Configuration
- `MASTER_TIMEOUT_EN` defined:
  - An idle counter clears on entry to WAIT_ACK and RDATA, and on each `svalid` in RDATA.
  - The counter increments on every other cycle in those states.
  - At ACK_TIMEOUT the block goes to DONE with `derr`=1.
- Undefined: no counter; WAIT_ACK and RDATA wait indefinitely.

## Test plan
- Write, ADDR_WIDTH=14/DATA_WIDTH=8, `daddr`=0x1A5C, `dwdata`=0xA5, grant 1 cycle, `sack` 2 cycles after ADDR -> serial stream 0x1A5C then 0xA5 (LSB first), `mmode`=1, one `drvalid` pulse, `breq` low in DONE.
- Read of `daddr`=0x2003, slave returns 0x3C with `svalid` gaps of 1 cycle -> `drdata`=0x3C, one `drvalid` pulse, `mvalid`=0 during RDATA.
- Grant withheld 10 cycles -> `breq` held 1 throughout, `mvalid` stays 0 until the cycle after `bgrant`.
- `bgrant` dropped mid-ADDR -> `derr` pulse, `drvalid`=0, `drdata` unchanged, return to IDLE.
- With MASTER_TIMEOUT_EN and ACK_TIMEOUT=16, no `sack` -> `derr` 16 cycles after entering WAIT_ACK. Without the macro -> port remains in WAIT_ACK with `breq`=1.
- `rstn` pulsed low during WDATA -> all outputs at reset values immediately. A new write afterward completes normally.

Source files
------------

// File: rtl/master_port.sv
// -----------------------------------------------------------------------------
// master_port
//
// Bus-side master for the two-master system bus. It takes one parallel
// read/write request from a local device, asks the arbiter for the bus, and
// then moves the frame one bit per cycle:
//   write frame : address (LSB first), wait for slave ack, write data (LSB first)
//   read frame  : address (LSB first), wait for slave ack, collect read data
//
// Losing the grant before the frame is complete aborts the frame. The device
// then sees a derr pulse instead of drvalid, and drdata keeps its old value.
//
// Optional feature (macro MASTER_TIMEOUT_EN):
//   An idle counter runs while the port waits for sack in WAIT_ACK, or for
//   svalid in RDATA. When it reaches ACK_TIMEOUT the frame is aborted with
//   derr. Without the macro these two states wait indefinitely, and the
//   ACK_TIMEOUT parameter does not exist.
//
// Ports
//   clk, rstn       : clock (rising edge); asynchronous active-low reset
//   dvalid, dmode   : device request strobe; mode (1 = write, 0 = read)
//   daddr, dwdata   : target address (top 2 bits = slave id); write data
//   dready          : port idle; a request is taken this cycle if dvalid = 1
//   drvalid, derr   : one-cycle completion pulse / one-cycle abort pulse
//   drdata          : last read data, held until the next read completes
//   breq, bgrant    : bus request to the arbiter / bus grant from the arbiter
//   mwdata, mvalid  : serial address/write-data bit and its valid flag
//   mmode           : latched mode, driven for the whole frame
//   sack            : slave address acknowledge
//   svalid, mrdata  : serial read-data valid flag and read-data bit
//
// Every output is either a register or a decode of registers. No input
// reaches an output combinationally.
// -----------------------------------------------------------------------------
module master_port #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 8
`ifdef MASTER_TIMEOUT_EN
    ,
    parameter int ACK_TIMEOUT = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rstn,
    // device side
    input  logic                  dvalid,
    input  logic                  dmode,
    input  logic [ADDR_WIDTH-1:0] daddr,
    input  logic [DATA_WIDTH-1:0] dwdata,
    output logic                  dready,
    output logic                  drvalid,
    output logic [DATA_WIDTH-1:0] drdata,
    output logic                  derr,
    // arbiter side
    output logic                  breq,
    input  logic                  bgrant,
    // serial bus side
    output logic                  mwdata,
    output logic                  mvalid,
    output logic                  mmode,
    input  logic                  sack,
    input  logic                  svalid,
    input  logic                  mrdata
);

    // One bit counter serves the address phase and the data phases.
    localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

`ifdef MASTER_TIMEOUT_EN
    localparam int IDLE_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(ACK_TIMEOUT - 1);
    localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ADDR,
        S_WAIT_ACK,
        S_WDATA,
        S_RDATA,
        S_DONE
    } state_e;

    state_e                state_q,    state_d;
    logic [CNT_W-1:0]      bit_cnt_q,  bit_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_sr_q,  addr_sr_d;   // shifts right; bit 0 goes out
    logic [DATA_WIDTH-1:0] wdata_sr_q, wdata_sr_d;  // shifts right; bit 0 goes out
    logic                  mode_q,     mode_d;
    logic [DATA_WIDTH-1:0] rx_q,       rx_d;        // filled from the MSB end
    logic [DATA_WIDTH-1:0] drdata_q,   drdata_d;
    logic                  err_q,      err_d;       // current frame is aborting
`ifdef MASTER_TIMEOUT_EN
    logic [IDLE_W-1:0]     idle_q,     idle_d;
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every _d signal takes its hold value before the case, so no
        // branch can leave one unassigned and no latch can be inferred.
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        addr_sr_d  = addr_sr_q;
        wdata_sr_d = wdata_sr_q;
        mode_d     = mode_q;
        rx_d       = rx_q;
        drdata_d   = drdata_q;
        err_d      = err_q;
`ifdef MASTER_TIMEOUT_EN
        // The counter stays at zero outside the two waiting states. Entering
        // WAIT_ACK or RDATA therefore always starts it from zero.
        idle_d     = '0;
`endif

        case (state_q)
            S_IDLE: begin
                err_d = 1'b0;
                if (dvalid) begin
                    addr_sr_d  = daddr;
                    wdata_sr_d = dwdata;
                    mode_d     = dmode;
                    bit_cnt_d  = '0;
                    state_d    = S_REQ;
                end
            end

            S_REQ: begin
                if (bgrant) begin
                    bit_cnt_d = '0;
                    state_d   = S_ADDR;
                end
            end

            S_ADDR: begin
                if (!bgrant) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    addr_sr_d = addr_sr_q >> 1;
                    if (bit_cnt_q == ADDR_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = S_WAIT_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_ONE;
                    end
                end
            end

            S_WAIT_ACK: begin
                if (!bgrant) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (sack) begin
                    bit_cnt_d = '0;
                    state_d   = mode_q ? S_WDATA : S_RDATA;
                end
`ifdef MASTER_TIMEOUT_EN
                else if (idle_q == IDLE_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idle_d = idle_q + IDLE_ONE;
                end
`endif
            end

            S_WDATA: begin
                if (!bgrant) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wdata_sr_d = wdata_sr_q >> 1;
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = S_DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_ONE;
                    end
                end
            end

            S_RDATA: begin
                if (!bgrant) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (svalid) begin
                    // Bits arrive LSB first. Each one enters at the top and moves
                    // down, so after DATA_WIDTH bits the first one sits at bit 0.
                    rx_d = {mrdata, rx_q[DATA_WIDTH-1:1]};
                    if (bit_cnt_q == DATA_LAST) begin
                        drdata_d  = rx_d;
                        bit_cnt_d = '0;
                        state_d   = S_DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_ONE;
                    end
                end
`ifdef MASTER_TIMEOUT_EN
                else if (idle_q == IDLE_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idle_d = idle_q + IDLE_ONE;
                end
`endif
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples pre-edge values, whatever the order of the statements.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            addr_sr_q  <= '0;
            wdata_sr_q <= '0;
            mode_q     <= 1'b0;
            rx_q       <= '0;
            drdata_q   <= '0;
            err_q      <= 1'b0;
`ifdef MASTER_TIMEOUT_EN
            idle_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            addr_sr_q  <= addr_sr_d;
            wdata_sr_q <= wdata_sr_d;
            mode_q     <= mode_d;
            rx_q       <= rx_d;
            drdata_q   <= drdata_d;
            err_q      <= err_d;
`ifdef MASTER_TIMEOUT_EN
            idle_q     <= idle_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Outputs, decoded from registered state only
    // -------------------------------------------------------------------------
    // breq stays high from REQ through RDATA, so the arbiter holds the grant
    // for the whole frame. It drops in DONE, which releases the bus.
    assign dready  = (state_q == S_IDLE);
    assign breq    = (state_q == S_REQ)      || (state_q == S_ADDR)  ||
                     (state_q == S_WAIT_ACK) || (state_q == S_WDATA) ||
                     (state_q == S_RDATA);
    assign mvalid  = (state_q == S_ADDR) || (state_q == S_WDATA);
    assign mmode   = (state_q != S_IDLE) && mode_q;
    assign drvalid = (state_q == S_DONE) && !err_q;
    assign derr    = (state_q == S_DONE) &&  err_q;
    assign drdata  = drdata_q;

    always_comb begin
        mwdata = 1'b0;
        if (state_q == S_ADDR) begin
            mwdata = addr_sr_q[0];
        end else if (state_q == S_WDATA) begin
            mwdata = wdata_sr_q[0];
        end
    end

endmodule

// File: tb/tb_master_port.sv
// -----------------------------------------------------------------------------
// tb_master_port
//
// Directed bench for master_port with default widths (ADDR_WIDTH = 14,
// DATA_WIDTH = 8). A table of per-cycle records drives one complete write
// frame and one complete read frame. Each record holds the inputs for a cycle
// and the outputs expected during that cycle. Hand-written sequences cover the
// multi-cycle corner cases: grant withheld, grant lost in ADDR and in RDATA,
// missing sack (with or without MASTER_TIMEOUT_EN), and reset during WDATA
// followed by a clean write.
//
// Inputs change and outputs are checked 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_master_port;

    localparam int AW = 14;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          dvalid;
    logic          dmode;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dwdata;
    logic          dready;
    logic          drvalid;
    logic [DW-1:0] drdata;
    logic          derr;
    logic          breq;
    logic          bgrant;
    logic          mwdata;
    logic          mvalid;
    logic          mmode;
    logic          sack;
    logic          svalid;
    logic          mrdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    master_port dut (
        .clk     (clk),
        .rstn    (rstn),
        .dvalid  (dvalid),
        .dmode   (dmode),
        .daddr   (daddr),
        .dwdata  (dwdata),
        .dready  (dready),
        .drvalid (drvalid),
        .drdata  (drdata),
        .derr    (derr),
        .breq    (breq),
        .bgrant  (bgrant),
        .mwdata  (mwdata),
        .mvalid  (mvalid),
        .mmode   (mmode),
        .sack    (sack),
        .svalid  (svalid),
        .mrdata  (mrdata)
    );

    // exp packs the expected outputs as {dready, breq, mvalid, mwdata, mmode, drvalid, derr}
    typedef struct {
        logic          dvalid;
        logic          dmode;
        logic [AW-1:0] daddr;
        logic [DW-1:0] dwdata;
        logic          bgrant;
        logic          sack;
        logic          svalid;
        logic          mrdata;
        logic [6:0]    exp;
        logic [DW-1:0] exp_drdata;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic g, input logic s, input logic sv, input logic md,
                                input logic [6:0] e, input logic [DW-1:0] d);
        vec_t v;
        v.dvalid     = 1'b0;
        v.dmode      = 1'b0;
        v.daddr      = '0;
        v.dwdata     = '0;
        v.bgrant     = g;
        v.sack       = s;
        v.svalid     = sv;
        v.mrdata     = md;
        v.exp        = e;
        v.exp_drdata = d;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [6:0] e, input logic [DW-1:0] d);
        check({tag, " dready"},  32'(dready),  32'(e[6]));
        check({tag, " breq"},    32'(breq),    32'(e[5]));
        check({tag, " mvalid"},  32'(mvalid),  32'(e[4]));
        check({tag, " mwdata"},  32'(mwdata),  32'(e[3]));
        check({tag, " mmode"},   32'(mmode),   32'(e[2]));
        check({tag, " drvalid"}, 32'(drvalid), 32'(e[1]));
        check({tag, " derr"},    32'(derr),    32'(e[0]));
        check({tag, " drdata"},  32'(drdata),  32'(d));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        dvalid = 1'b0;
        dmode  = 1'b0;
        daddr  = '0;
        dwdata = '0;
        bgrant = 1'b0;
        sack   = 1'b0;
        svalid = 1'b0;
        mrdata = 1'b0;
    endtask

    // Presents a request during an IDLE cycle; returns in the first REQ cycle.
    task automatic accept(input logic m, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [DW-1:0] drd, input string tag);
        dvalid = 1'b1;
        dmode  = m;
        daddr  = a;
        dwdata = d;
        check_outs({tag, " accept"}, 7'b1000000, drd);
        tick();
        dvalid = 1'b0;
        daddr  = '0;
        dwdata = '0;
    endtask

    // Complete write: grant at once, sack in the first WAIT_ACK cycle.
    task automatic run_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [DW-1:0] drd, input string tag);
        accept(1'b1, a, d, drd, tag);
        bgrant = 1'b1;
        check_outs({tag, " req"}, 7'b0100100, drd);
        tick();
        for (int k = 0; k < AW; k++) begin
            check_outs($sformatf("%s addr%0d", tag, k), {1'b0, 1'b1, 1'b1, a[k], 1'b1, 2'b00}, drd);
            tick();
        end
        sack = 1'b1;
        check_outs({tag, " wait"}, 7'b0100100, drd);
        tick();
        sack = 1'b0;
        for (int k = 0; k < DW; k++) begin
            check_outs($sformatf("%s wdata%0d", tag, k), {1'b0, 1'b1, 1'b1, d[k], 1'b1, 2'b00}, drd);
            tick();
        end
        bgrant = 1'b0;
        check_outs({tag, " done"}, 7'b0000110, drd);
        tick();
        check_outs({tag, " idle"}, 7'b1000000, drd);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] wr_addr;
        logic [DW-1:0] wr_data;
        logic [AW-1:0] rd_addr;
        logic [DW-1:0] rd_data;
        logic [AW-1:0] ga;
        vec_t          v;

        wr_addr = 14'h1A5C;
        wr_data = 8'hA5;
        rd_addr = 14'h2003;
        rd_data = 8'h3C;

        // ---- write frame: grant 1 cycle after breq, sack 2 cycles after ADDR
        v = mk(1'b0, 1'b0, 1'b0, 1'b0, 7'b1000000, 8'h00);
        v.dvalid = 1'b1; v.dmode = 1'b1; v.daddr = wr_addr; v.dwdata = wr_data;
        tbl.push_back(v);
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 7'b0100100, 8'h00));     // REQ, no grant
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 7'b0100100, 8'h00));     // REQ, grant seen
        for (int k = 0; k < AW; k++) begin
            v = mk(1'b1, 1'b0, 1'b0, 1'b0, {1'b0, 1'b1, 1'b1, wr_addr[k], 1'b1, 2'b00}, 8'h00);
            if (k == 2) begin
                // a request outside IDLE must be ignored
                v.dvalid = 1'b1; v.dmode = 1'b0; v.daddr = 14'h0000; v.dwdata = 8'h00;
            end
            tbl.push_back(v);
        end
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 7'b0100100, 8'h00));     // WAIT_ACK
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 7'b0100100, 8'h00));     // WAIT_ACK, sack
        for (int k = 0; k < DW; k++) begin
            tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, {1'b0, 1'b1, 1'b1, wr_data[k], 1'b1, 2'b00}, 8'h00));
        end
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 7'b0000110, 8'h00));     // DONE
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 7'b1000000, 8'h00));     // IDLE

        // ---- read frame: immediate grant and ack, one-cycle gap before each bit
        v = mk(1'b0, 1'b0, 1'b0, 1'b0, 7'b1000000, 8'h00);
        v.dvalid = 1'b1; v.dmode = 1'b0; v.daddr = rd_addr; v.dwdata = 8'hFF;
        tbl.push_back(v);
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 7'b0100000, 8'h00));     // REQ, grant
        for (int k = 0; k < AW; k++) begin
            tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, {1'b0, 1'b1, 1'b1, rd_addr[k], 1'b0, 2'b00}, 8'h00));
        end
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 7'b0100000, 8'h00));     // WAIT_ACK, sack
        for (int k = 0; k < DW; k++) begin
            tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 7'b0100000, 8'h00)); // gap, mrdata ignored
            tbl.push_back(mk(1'b1, 1'b0, 1'b1, rd_data[k], 7'b0100000, 8'h00));
        end
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 7'b0000010, 8'h3C));     // DONE
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 7'b1000000, 8'h3C));     // IDLE

        // ---- reset state
        rstn = 1'b0;
        quiet_inputs();
        tick();
        tick();
        check_outs("reset", 7'b1000000, 8'h00);
        rstn = 1'b1;

        // ---- table
        foreach (tbl[i]) begin
            dvalid = tbl[i].dvalid;
            dmode  = tbl[i].dmode;
            daddr  = tbl[i].daddr;
            dwdata = tbl[i].dwdata;
            bgrant = tbl[i].bgrant;
            sack   = tbl[i].sack;
            svalid = tbl[i].svalid;
            mrdata = tbl[i].mrdata;
            check_outs($sformatf("vec%0d", i), tbl[i].exp, tbl[i].exp_drdata);
            tick();
        end
        quiet_inputs();

        // ---- grant withheld 10 cycles, then grant lost in the third ADDR cycle
        ga = 14'h2AAA;
        accept(1'b0, ga, 8'h00, 8'h3C, "gw");
        for (int i = 0; i < 10; i++) begin
            check_outs($sformatf("gw req%0d", i), 7'b0100000, 8'h3C);
            tick();
        end
        bgrant = 1'b1;
        check_outs("gw grant", 7'b0100000, 8'h3C);
        tick();
        for (int k = 0; k < 3; k++) begin
            if (k == 2) bgrant = 1'b0;
            check_outs($sformatf("gw addr%0d", k), {1'b0, 1'b1, 1'b1, ga[k], 1'b0, 2'b00}, 8'h3C);
            tick();
        end
        check_outs("gw done", 7'b0000001, 8'h3C);
        tick();
        check_outs("gw idle", 7'b1000000, 8'h3C);

        // ---- grant lost partway through RDATA: drdata must keep 0x3C
        accept(1'b0, 14'h1234, 8'h00, 8'h3C, "ra");
        bgrant = 1'b1;
        tick();
        for (int k = 0; k < AW; k++) tick();
        sack = 1'b1;
        check_outs("ra wait", 7'b0100000, 8'h3C);
        tick();
        sack   = 1'b0;
        svalid = 1'b1;
        mrdata = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check_outs($sformatf("ra rdata%0d", k), 7'b0100000, 8'h3C);
            tick();
        end
        bgrant = 1'b0;
        check_outs("ra drop", 7'b0100000, 8'h3C);
        tick();
        svalid = 1'b0;
        mrdata = 1'b0;
        check_outs("ra done", 7'b0000001, 8'h3C);
        tick();
        check_outs("ra idle", 7'b1000000, 8'h3C);

        // ---- no sack from the slave
        accept(1'b1, 14'h0F0F, 8'h11, 8'h3C, "to");
        bgrant = 1'b1;
        tick();
        for (int k = 0; k < AW; k++) tick();
`ifdef MASTER_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            check_outs($sformatf("to wait%0d", i), 7'b0100100, 8'h3C);
            tick();
        end
        check_outs("to done", 7'b0000101, 8'h3C);
        bgrant = 1'b0;
        tick();
`else
        for (int i = 0; i < 40; i++) begin
            check_outs($sformatf("to wait%0d", i), 7'b0100100, 8'h3C);
            tick();
        end
        bgrant = 1'b0;
        check_outs("to drop", 7'b0100100, 8'h3C);
        tick();
        check_outs("to done", 7'b0000101, 8'h3C);
        tick();
`endif
        check_outs("to idle", 7'b1000000, 8'h3C);

        // ---- asynchronous reset during WDATA
        accept(1'b1, 14'h3001, 8'h5A, 8'h3C, "rw");
        bgrant = 1'b1;
        tick();
        for (int k = 0; k < AW; k++) tick();
        sack = 1'b1;
        tick();
        sack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_outs($sformatf("rw wdata%0d", k), {1'b0, 1'b1, 1'b1, wr_data_bit(8'h5A, k), 1'b1, 2'b00}, 8'h3C);
            tick();
        end
        #2;
        rstn = 1'b0;
        #1;
        check_outs("rw in_reset", 7'b1000000, 8'h00);
        quiet_inputs();
        tick();
        tick();
        rstn = 1'b1;
        check_outs("rw released", 7'b1000000, 8'h00);
        tick();

        // ---- a clean write after the reset
        run_write(14'h0155, 8'h3E, 8'h00, "pw");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    function automatic logic wr_data_bit(input logic [DW-1:0] d, input int k);
        return d[k];
    endfunction

endmodule
